phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 The block SHALL have parameter P1_LEN, default 2, meaning phi1 (cp1) high length in clk0 cycles, legal range 1..15.
REQ-002 The block SHALL have parameter P2_LEN, default 2, meaning phi2 (cclk) high length in clk0 cycles, legal range 1..15.
REQ-003 The block SHALL have parameter GAP, default 1, meaning non-overlap dead time in clk0 cycles between phases, legal range 1..15; 0 is illegal.
REQ-004 The block SHALL have port clk0, input, width 1: the single clock; all logic runs on its rising edge.
REQ-005 The block SHALL have port res, input, width 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port halt, input, width 1: request to stretch phi1; level-sensitive.
REQ-007 The block SHALL have port step, input, width 1: single-cycle pulse that releases one full machine cycle while halted.
REQ-008 The block SHALL have port cp1, output, width 1: phase-1 clock enable, registered.
REQ-009 The block SHALL have port cclk, output, width 1: phase-2 clock enable, registered.
REQ-010 The block SHALL have port cycle_start, output, width 1: one-clock pulse on the first P1 cycle.
REQ-011 The block SHALL have port halted, output, width 1: high while phi1 is being stretched.
REQ-012 The block SHALL have port cycle_count, output, width 16: count of P1 entries.

Function
REQ-013 The FSM SHALL have exactly the states G21, P1, G12 and P2, sequenced G21->P1->G12->P2->G21, driven by a 4-bit phase counter cnt.
REQ-014 G21 and G12 SHALL each last GAP cycles, P2 SHALL last P2_LEN cycles, and P1 SHALL last at least P1_LEN cycles; cnt SHALL clear on every state change.
REQ-015 cp1 SHALL be 1 iff state==P1, cclk SHALL be 1 iff state==P2, and they SHALL never be 1 simultaneously.
REQ-016 P1 SHALL exit at cnt==P1_LEN-1 only if halt==0 or step_credit==1; otherwise P1 SHALL hold, with cnt saturating at P1_LEN-1.
REQ-017 halted SHALL be 1 iff state==P1, cnt==P1_LEN-1, halt==1 and step_credit==0.
REQ-018 step_credit SHALL be set by step==1 while halted==1, SHALL be cleared on the P1 exit edge, and step SHALL be ignored when halted==0.
REQ-019 Each credit SHALL release exactly one machine cycle; if halt is still 1 at the next P1 end, the FSM SHALL stall again.
REQ-020 halt asserted during G21, G12 or P2 SHALL take effect at the end of the next P1; halt never truncates P2 or a gap.
REQ-021 Simultaneous halt deassertion and step SHALL produce a single exit with credit cleared, and no extra cycle SHALL be released.
REQ-022 cycle_start SHALL pulse on the clock following P1 entry; cycle_count SHALL increment on P1 entry and wrap 0xFFFF->0x0000.
REQ-023 The unstalled period SHALL be P1_LEN+P2_LEN+2*GAP clk0 cycles.

Reset
REQ-024 res==0 SHALL asynchronously force state=G21, cnt=0, step_credit=0, cp1=0, cclk=0, cycle_start=0, halted=0 and cycle_count=0.
REQ-025 Reset asserted mid-phase SHALL drop cp1 and cclk immediately, without completing the phase.
REQ-026 After res rises, the first P1 SHALL begin GAP clk0 edges later.

Structure
REQ-027 Shared package phase_seq_pkg SHALL hold the state enum (G21, P1, G12, P2) and the default constants P1_LEN_DEF=2, P2_LEN_DEF=2 and GAP_DEF=1.
REQ-028 The phase counter with its terminal-count compare SHALL be one sub-module named phase_counter; the FSM, credit and cycle counter SHALL stay in the top level.
REQ-029 An elaboration-time check SHALL reject GAP==0 or any parameter >15.

Verification
REQ-030 The bench SHALL cover default parameters with res released and halt=0: cp1 high after edges 1-2, cclk high after edges 4-5, period 6, no overlap over 1000 cycles.
REQ-031 The bench SHALL cover halt=1 before the first P1: cp1 stays 1, halted=1 from edge 2, cycle_count=1 and stable for 50 cycles.
REQ-032 The bench SHALL cover step pulses while halted: each pulse yields exactly one G12/P2/G21 sequence, cycle_count+1 per pulse, then a re-stall.
REQ-033 The bench SHALL cover step while not halted: no effect on period or count.
REQ-034 The bench SHALL cover P1_LEN=3, P2_LEN=1, GAP=2: period 8, cp1 high 3 cycles, cclk high 1 cycle; reset asserted mid-P2 drops cclk combinationally from the reset edge.
REQ-035 The bench SHALL cover a cycle_count preloaded near wrap via 65535 free-running cycles: the next P1 entry reads 0x0000 with a cycle_start pulse.

Source files
------------

// File: rtl/phase_seq_pkg.sv
// Shared types and default timing constants for the two-phase non-overlapping
// clock-enable sequencer.
package phase_seq_pkg;

  typedef enum logic [1:0] {
    G21,
    P1,
    G12,
    P2
  } phase_t;

  localparam int P1_LEN_DEF = 2;
  localparam int P2_LEN_DEF = 2;
  localparam int GAP_DEF    = 1;

endpackage

// File: rtl/phase_sequencer_counter.sv
// Phase-length counter: counts up to the current phase limit, saturates there,
// and restarts from zero whenever the sequencer changes phase.
module phase_counter
  import phase_seq_pkg::*;
(
  input  logic       clk0,
  input  logic       res,
  input  logic       clr,
  input  logic [3:0] limit,
  output logic [3:0] cnt,
  output logic [3:0] cnt_nxt,
  output logic       tc
);

  assign tc = (cnt == limit);

  // Holding at the limit lets a stretched phi1 sit on its last cycle.
  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (!tc) begin
      cnt_nxt = cnt + 4'd1;
    end
  end

  always_ff @(posedge clk0 or negedge res) begin
    if (!res) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/phase_sequencer.sv
// Two-phase non-overlapping clock-enable generator with halt/single-step
// control of phi1 and a free-running machine-cycle counter.
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int P1_LEN = P1_LEN_DEF,
  parameter int P2_LEN = P2_LEN_DEF,
  parameter int GAP    = GAP_DEF
) (
  input  logic        clk0,
  input  logic        res,
  input  logic        halt,
  input  logic        step,
  output logic        cp1,
  output logic        cclk,
  output logic        cycle_start,
  output logic        halted,
  output logic [15:0] cycle_count
);

  if (GAP < 1 || GAP > 15 || P1_LEN < 1 || P1_LEN > 15 || P2_LEN < 1 || P2_LEN > 15) begin : g_bad_params
    $error("phase_sequencer: P1_LEN, P2_LEN and GAP must each be in 1..15");
  end

  localparam logic [3:0] P1_LIM  = 4'(P1_LEN - 1);
  localparam logic [3:0] P2_LIM  = 4'(P2_LEN - 1);
  localparam logic [3:0] GAP_LIM = 4'(GAP - 1);

  phase_t     state;
  phase_t     state_nxt;
  logic       credit;
  logic       credit_nxt;
  logic       advance;
  logic       enter_p1;
  logic       halted_nxt;
  logic       tc;
  logic [3:0] limit;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;

  phase_counter u_counter (
    .clk0    (clk0),
    .res     (res),
    .clr     (advance),
    .limit   (limit),
    .cnt     (cnt),
    .cnt_nxt (cnt_nxt),
    .tc      (tc)
  );

  // Only P1 may overstay its limit: it waits for halt to drop or a step credit.
  always_comb begin
    limit     = GAP_LIM;
    state_nxt = state;
    case (state)
      P1:      limit = P1_LIM;
      P2:      limit = P2_LIM;
      default: limit = GAP_LIM;
    endcase
    advance = tc && ((state != P1) || !halt || credit);
    if (advance) begin
      case (state)
        G21:     state_nxt = P1;
        P1:      state_nxt = G12;
        G12:     state_nxt = P2;
        P2:      state_nxt = G21;
        default: state_nxt = G21;
      endcase
    end
    credit_nxt = credit;
    if (advance && (state == P1)) begin
      credit_nxt = 1'b0;
    end else if (step && halted) begin
      credit_nxt = 1'b1;
    end
    enter_p1   = (state_nxt == P1) && (state != P1);
    halted_nxt = (state_nxt == P1) && (cnt_nxt == P1_LIM) && halt && !credit_nxt;
  end

  always_ff @(posedge clk0 or negedge res) begin
    if (!res) begin
      state       <= G21;
      credit      <= 1'b0;
      cp1         <= 1'b0;
      cclk        <= 1'b0;
      cycle_start <= 1'b0;
      halted      <= 1'b0;
      cycle_count <= '0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      cp1         <= (state_nxt == P1);
      cclk        <= (state_nxt == P2);
      cycle_start <= enter_p1;
      halted      <= halted_nxt;
      cycle_count <= cycle_count + {15'd0, enter_p1};
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: default timing with halt/step control on
// one instance, and a 3/1/2 timing instance for period and mid-phase reset.
module tb_phase_sequencer;

  logic        clk0 = 1'b0;
  logic        res_a, halt_a, step_a;
  logic        cp1_a, cclk_a, cycle_start_a, halted_a;
  logic [15:0] cycle_count_a;
  logic        res_b, halt_b, step_b;
  logic        cp1_b, cclk_b, cycle_start_b, halted_b;
  logic [15:0] cycle_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk0 = ~clk0;

  phase_sequencer dut_a (
    .clk0        (clk0),
    .res         (res_a),
    .halt        (halt_a),
    .step        (step_a),
    .cp1         (cp1_a),
    .cclk        (cclk_a),
    .cycle_start (cycle_start_a),
    .halted      (halted_a),
    .cycle_count (cycle_count_a)
  );

  phase_sequencer #(.P1_LEN(3), .P2_LEN(1), .GAP(2)) dut_b (
    .clk0        (clk0),
    .res         (res_b),
    .halt        (halt_b),
    .step        (step_b),
    .cp1         (cp1_b),
    .cclk        (cclk_b),
    .cycle_start (cycle_start_b),
    .halted      (halted_b),
    .cycle_count (cycle_count_b)
  );

  typedef struct {
    logic        halt;
    logic        step;
    logic        cp1;
    logic        cclk;
    logic        cs;
    logic        halted;
    logic [15:0] count;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic h, input logic s, input logic c1, input logic c2,
                        input logic cs, input logic hd, input logic [15:0] n);
    vec_t v;
    v.halt = h; v.step = s; v.cp1 = c1; v.cclk = c2; v.cs = cs; v.halted = hd; v.count = n;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic h, input logic s);
    halt_a = h;
    step_a = s;
  endtask

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          edges;
    int          cclk_edges;
    logic        seen;
    logic [15:0] exp_count;
    int          ph;

    // halt, step | cp1, cclk, cycle_start, halted, cycle_count  (one row per edge)
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd1);
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd2);
    addVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd2);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd2);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd2);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd3);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd3);
    addVec(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd3);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
    addVec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    addVec(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    addVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd3);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd4);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd4);
    addVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    addVec(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd4);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd4);
    addVec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd5);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5);
    addVec(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd5);
    addVec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd5);

    res_a = 1'b0; halt_a = 1'b0; step_a = 1'b0;
    res_b = 1'b0; halt_b = 1'b0; step_b = 1'b0;
    repeat (3) @(posedge clk0);
    #1;
    checkOutput("reset cp1", 16'(cp1_a), 16'd0);
    checkOutput("reset cclk", 16'(cclk_a), 16'd0);
    checkOutput("reset cycle_start", 16'(cycle_start_a), 16'd0);
    checkOutput("reset halted", 16'(halted_a), 16'd0);
    checkOutput("reset cycle_count", cycle_count_a, 16'd0);

    $display("[TB] table-driven vectors, default timing");
    @(negedge clk0);
    res_a = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].halt, vecs[i].step);
      @(posedge clk0);
      #1;
      checkOutput($sformatf("vec%0d cp1", i), 16'(cp1_a), 16'(vecs[i].cp1));
      checkOutput($sformatf("vec%0d cclk", i), 16'(cclk_a), 16'(vecs[i].cclk));
      checkOutput($sformatf("vec%0d cycle_start", i), 16'(cycle_start_a), 16'(vecs[i].cs));
      checkOutput($sformatf("vec%0d halted", i), 16'(halted_a), 16'(vecs[i].halted));
      checkOutput($sformatf("vec%0d cycle_count", i), cycle_count_a, vecs[i].count);
    end

    $display("[TB] halt held from reset, then single steps");
    res_a = 1'b0;
    #1;
    checkOutput("async reset cp1", 16'(cp1_a), 16'd0);
    checkOutput("async reset cycle_count", cycle_count_a, 16'd0);
    applyStimulus(1'b1, 1'b0);
    @(negedge clk0);
    res_a = 1'b1;
    for (int t = 1; t <= 50; t++) begin
      @(posedge clk0);
      #1;
      checkOutput($sformatf("stall e%0d cp1", t), 16'(cp1_a), 16'd1);
      checkOutput($sformatf("stall e%0d cclk", t), 16'(cclk_a), 16'd0);
      checkOutput($sformatf("stall e%0d halted", t), 16'(halted_a), 16'(t >= 2));
      checkOutput($sformatf("stall e%0d cycle_count", t), cycle_count_a, 16'd1);
    end

    exp_count = 16'd1;
    for (int p = 0; p < 3; p++) begin
      applyStimulus(1'b1, 1'b1);
      @(posedge clk0);
      #1;
      applyStimulus(1'b1, 1'b0);
      edges = 0;
      cclk_edges = 0;
      seen = 1'b0;
      while (!seen && edges < 20) begin
        @(posedge clk0);
        #1;
        edges++;
        if (cclk_a) cclk_edges++;
        if (cycle_start_a) seen = 1'b1;
      end
      exp_count = exp_count + 16'd1;
      checkOutput($sformatf("step%0d cycle_start seen", p), 16'(seen), 16'd1);
      checkOutput($sformatf("step%0d edges to next P1", p), 16'(edges), 16'd5);
      checkOutput($sformatf("step%0d cclk cycles", p), 16'(cclk_edges), 16'd2);
      checkOutput($sformatf("step%0d cycle_count", p), cycle_count_a, exp_count);
      repeat (2) @(posedge clk0);
      #1;
      checkOutput($sformatf("step%0d restall halted", p), 16'(halted_a), 16'd1);
      checkOutput($sformatf("step%0d restall cp1", p), 16'(cp1_a), 16'd1);
      checkOutput($sformatf("step%0d restall cycle_count", p), cycle_count_a, exp_count);
    end

    $display("[TB] free run 1000 cycles with ignored step pulses");
    res_a = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk0);
    res_a = 1'b1;
    for (int t = 1; t <= 1000; t++) begin
      applyStimulus(1'b0, (t % 37) == 0);
      @(posedge clk0);
      #1;
      ph = (t - 1) % 6;
      checkOutput($sformatf("run e%0d cp1", t), 16'(cp1_a), 16'(ph < 2));
      checkOutput($sformatf("run e%0d cclk", t), 16'(cclk_a), 16'(ph == 3 || ph == 4));
      checkOutput($sformatf("run e%0d cycle_start", t), 16'(cycle_start_a), 16'(ph == 0));
      checkOutput($sformatf("run e%0d overlap", t), 16'(cp1_a & cclk_a), 16'd0);
    end
    applyStimulus(1'b0, 1'b0);
    checkOutput("run cycle_count after 1000", cycle_count_a, 16'd167);
    checkOutput("run halted", 16'(halted_a), 16'd0);

    $display("[TB] P1_LEN=3 P2_LEN=1 GAP=2 timing and mid-P2 reset");
    @(negedge clk0);
    res_b = 1'b1;
    for (int t = 1; t <= 47; t++) begin
      @(posedge clk0);
      #1;
      if (t < 2) begin
        checkOutput("b e1 cp1", 16'(cp1_b), 16'd0);
        checkOutput("b e1 cycle_count", cycle_count_b, 16'd0);
      end else begin
        ph = (t - 2) % 8;
        checkOutput($sformatf("b e%0d cp1", t), 16'(cp1_b), 16'(ph <= 2));
        checkOutput($sformatf("b e%0d cclk", t), 16'(cclk_b), 16'(ph == 5));
        checkOutput($sformatf("b e%0d cycle_start", t), 16'(cycle_start_b), 16'(ph == 0));
        checkOutput($sformatf("b e%0d cycle_count", t), cycle_count_b, 16'((t - 2) / 8 + 1));
      end
    end
    #2;
    res_b = 1'b0;
    #1;
    checkOutput("b mid-P2 reset cclk", 16'(cclk_b), 16'd0);
    checkOutput("b mid-P2 reset cp1", 16'(cp1_b), 16'd0);
    checkOutput("b mid-P2 reset cycle_count", cycle_count_b, 16'd0);
    @(posedge clk0);
    #1;
    checkOutput("b held reset cclk", 16'(cclk_b), 16'd0);

    $display("[TB] cycle_count wrap");
    res_a = 1'b0;
    applyStimulus(1'b0, 1'b0);
    @(negedge clk0);
    res_a = 1'b1;
    @(posedge clk0);
    #1;
    checkOutput("wrap e1 cycle_count", cycle_count_a, 16'd1);
    // Jump the counter next to its wrap point instead of running 65535 machine cycles.
    force dut_a.cycle_count = 16'hFFFE;
    @(posedge clk0);
    #1;
    release dut_a.cycle_count;
    checkOutput("wrap preload", cycle_count_a, 16'hFFFE);
    for (int t = 3; t <= 13; t++) begin
      @(posedge clk0);
      #1;
      ph = (t - 1) % 6;
      checkOutput($sformatf("wrap e%0d cycle_start", t), 16'(cycle_start_a), 16'(ph == 0));
      checkOutput($sformatf("wrap e%0d cycle_count", t), cycle_count_a,
                  (t < 7) ? 16'hFFFE : ((t < 13) ? 16'hFFFF : 16'h0000));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
